alu_bist: RTL and testbench

Built-in self-test sequencer for the single-cycle datapath ALU. It drives the ALU operand and control inputs from a fixed vector table, samples `res`/`zero`, and compares them against golden values. It sits beside the ALU in the core top level, muxed in front of the ALU inputs while `busy` is high. It is the on-chip initiator of the ALU interface and runs at power-up or when requested by debug logic.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_bist_rom.sv | 39 +++
 rtl/alu_bist.sv | 135 +++++++++++++
 tb/tb_alu_bist.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, BIST state encoding and vector count.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam int NUM_VECTORS = 10;

    typedef enum logic [1:0] {
        BIST_IDLE  = 2'd0,
        BIST_APPLY = 2'd1,
        BIST_CHECK = 2'd2,
        BIST_DONE  = 2'd3
    } bist_state_t;

endpackage

// File: rtl/alu_bist_rom.sv
// Fixed ALU self-test vector table with golden results; unused indices read as zero.
module alu_bist_rom
    import alu_pkg::*;
(
    input  logic [3:0]  idx,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  ctrl,
    output logic [31:0] exp_res,
    output logic        exp_zero
);

    localparam logic [31:0] PAT_A = 32'hAAAA_AAAA;
    localparam logic [31:0] PAT_B = 32'h5555_5555;
    localparam logic [31:0] SH_15 = 32'h0000_000F;

    // Table lookup; every output defaults to zero for out-of-range indices.
    always_comb begin
        a        = '0;
        b        = '0;
        ctrl     = '0;
        exp_res  = '0;
        exp_zero = 1'b0;
        case (idx)
            4'd0: begin ctrl = ALU_AND;  a = PAT_A; b = PAT_B; exp_res = 32'h0000_0000; exp_zero = 1'b1; end
            4'd1: begin ctrl = ALU_OR;   a = PAT_A; b = PAT_B; exp_res = 32'hFFFF_FFFF; end
            4'd2: begin ctrl = ALU_ADD;  a = PAT_A; b = PAT_B; exp_res = 32'hFFFF_FFFF; end
            4'd3: begin ctrl = ALU_SUB;  a = PAT_A; b = PAT_B; exp_res = 32'h5555_5555; end
            4'd4: begin ctrl = ALU_SLT;  a = PAT_A; b = PAT_B; exp_res = 32'h0000_0001; end
            4'd5: begin ctrl = ALU_SLL;  a = PAT_A; b = PAT_B; exp_res = 32'h5540_0000; end
            4'd6: begin ctrl = ALU_SRL;  a = PAT_A; b = SH_15; exp_res = 32'h0001_5555; end
            4'd7: begin ctrl = ALU_XOR;  a = PAT_A; b = PAT_B; exp_res = 32'hFFFF_FFFF; end
            4'd8: begin ctrl = ALU_SRA;  a = PAT_A; b = SH_15; exp_res = 32'hFFFF_5555; end
            4'd9: begin ctrl = ALU_SLTU; a = PAT_A; b = PAT_B; exp_res = 32'h0000_0000; exp_zero = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test sequencer: applies the vector table, checks res/zero, reports.
//
// state | meaning
// IDLE  | waiting for start; alu_* hold last vector
// APPLY | vector idx driven, settle counter running down
// CHECK | compare ALU outputs against golden on the exiting edge
// DONE  | done pulse, pass valid; start here chains straight into a new run
module alu_bist
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_cnt,
    output logic [3:0]  fail_idx,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_res,
    input  logic        alu_zero
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_IDX    = 4'(NUM_VECTORS - 1);

    bist_state_t state;
    logic [3:0]  idx;
    logic [3:0]  settle_cnt;

    logic [31:0] cur_a, cur_b, cur_exp_res;
    logic [3:0]  cur_ctrl;
    logic        cur_exp_zero;
    logic [31:0] nxt_a, nxt_b, nxt_exp_res;
    logic [3:0]  nxt_ctrl, nxt_idx;
    logic        nxt_exp_zero;
    logic        mismatch;

    // Golden values for the vector currently under check.
    alu_bist_rom u_rom_cur (
        .idx      (idx),
        .a        (cur_a),
        .b        (cur_b),
        .ctrl     (cur_ctrl),
        .exp_res  (cur_exp_res),
        .exp_zero (cur_exp_zero)
    );

    // Operands for the vector loaded on the next APPLY entry.
    alu_bist_rom u_rom_nxt (
        .idx      (nxt_idx),
        .a        (nxt_a),
        .b        (nxt_b),
        .ctrl     (nxt_ctrl),
        .exp_res  (nxt_exp_res),
        .exp_zero (nxt_exp_zero)
    );

    // Next vector index and current-vector mismatch detection.
    always_comb begin
        nxt_idx  = (state == BIST_CHECK) ? idx + 4'd1 : 4'd0;
        mismatch = (alu_res != cur_exp_res) || (alu_zero != cur_exp_zero);
    end

    // Sequencer FSM with settle/index counters and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= BIST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_idx   <= 4'hF;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                BIST_IDLE, BIST_DONE: begin
                    if (start) begin
                        state      <= BIST_APPLY;
                        busy       <= 1'b1;
                        idx        <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        err_cnt    <= '0;
                        fail_idx   <= 4'hF;
                        pass       <= 1'b0;
                        alu_a      <= nxt_a;
                        alu_b      <= nxt_b;
                        alu_ctrl   <= nxt_ctrl;
                    end else begin
                        state <= BIST_IDLE;
                    end
                end
                BIST_APPLY: begin
                    if (settle_cnt == 4'd0) begin
                        state <= BIST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                BIST_CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 4'd1;
                        if (fail_idx == 4'hF) begin
                            fail_idx <= idx;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= BIST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_cnt == 4'd0);
                    end else begin
                        state      <= BIST_APPLY;
                        idx        <= nxt_idx;
                        settle_cnt <= SETTLE_LOAD;
                        alu_a      <= nxt_a;
                        alu_b      <= nxt_b;
                        alu_ctrl   <= nxt_ctrl;
                    end
                end
                default: state <= BIST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench: two BIST instances (settle 1 and 3) each driving a bench ALU model.
module tb_alu_bist;

    logic clk;
    logic rstn;
    logic st [2];
    int   mode;

    logic        busy_o [2];
    logic        done_o [2];
    logic        pass_o [2];
    logic [3:0]  err_o  [2];
    logic [3:0]  fidx_o [2];
    logic [31:0] a_o    [2];
    logic [31:0] b_o    [2];
    logic [3:0]  ctrl_o [2];
    logic [31:0] res_i  [2];
    logic        zero_i [2];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit valid    = 0;

    localparam logic [3:0]  TV_C [10] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd4, 4'd5, 4'd3, 4'd8, 4'd9};
    localparam logic [31:0] TV_B [10] = '{32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555,
                                          32'h55555555, 32'h55555555, 32'h0000000F, 32'h55555555,
                                          32'h0000000F, 32'h55555555};
    localparam logic [31:0] TV_R [10] = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555,
                                          32'h00000001, 32'h55400000, 32'h00015555, 32'hFFFFFFFF,
                                          32'hFFFF5555, 32'h00000000};
    localparam logic        TV_Z [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] TV_A = 32'hAAAAAAAA;

    // Reference ALU; mode 1 = SRA done as logical shift, mode 2 = zero flag stuck at 0.
    function automatic logic [32:0] alu_fn(logic [3:0] c, logic [31:0] a, logic [31:0] b, int m);
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        case (c)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a + b;
            4'd3: r = a ^ b;
            4'd4: r = a << sh;
            4'd5: r = a >> sh;
            4'd6: r = a - b;
            4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: r = (m == 1) ? (a >> sh) : 32'($signed(a) >>> sh);
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {(m == 2) ? 1'b0 : (r == 32'd0), r};
    endfunction

    assign {zero_i[0], res_i[0]} = alu_fn(ctrl_o[0], a_o[0], b_o[0], mode);
    assign {zero_i[1], res_i[1]} = alu_fn(ctrl_o[1], a_o[1], b_o[1], mode);

    alu_bist #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rstn(rstn), .start(st[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .err_cnt(err_o[0]), .fail_idx(fidx_o[0]), .alu_a(a_o[0]),
        .alu_b(b_o[0]), .alu_ctrl(ctrl_o[0]), .alu_res(res_i[0]), .alu_zero(zero_i[0])
    );

    alu_bist #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rstn(rstn), .start(st[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .err_cnt(err_o[1]), .fail_idx(fidx_o[1]), .alu_a(a_o[1]),
        .alu_b(b_o[1]), .alu_ctrl(ctrl_o[1]), .alu_res(res_i[1]), .alu_zero(zero_i[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: a run is a cycle count k from acceptance; vector = k/(S+1), done at k=10(S+1).
    bit          m_run  [2];
    int          m_k    [2];
    int          m_err  [2];
    int          m_fidx [2];
    bit          m_pass [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    logic [3:0]  m_c    [2];

    always @(posedge clk) begin
        int sp, nn, k, v;
        logic [32:0] r;
        cyc++;
        for (int u = 0; u < 2; u++) begin
            sp = (u == 0) ? 1 : 3;
            nn = 10 * (sp + 1);
            if (!rstn) begin
                m_run[u] = 0; m_k[u] = 0; m_err[u] = 0; m_fidx[u] = 15; m_pass[u] = 0;
                m_a[u] = '0; m_b[u] = '0; m_c[u] = '0;
            end else if (!m_run[u] || m_k[u] == nn) begin
                if (st[u]) begin
                    m_run[u] = 1; m_k[u] = 0; m_err[u] = 0; m_fidx[u] = 15; m_pass[u] = 0;
                    m_a[u] = TV_A; m_b[u] = TV_B[0]; m_c[u] = TV_C[0];
                end else begin
                    m_run[u] = 0;
                end
            end else begin
                m_k[u]++;
                k = m_k[u];
                if (k % (sp + 1) == 0) begin
                    v = k / (sp + 1) - 1;
                    r = alu_fn(TV_C[v], TV_A, TV_B[v], mode);
                    if (r != {TV_Z[v], TV_R[v]}) begin
                        m_err[u]++;
                        if (m_fidx[u] == 15) m_fidx[u] = v;
                    end
                end
                if (k < nn) begin
                    v = k / (sp + 1);
                    m_a[u] = TV_A; m_b[u] = TV_B[v]; m_c[u] = TV_C[v];
                end else begin
                    m_pass[u] = (m_err[u] == 0);
                end
            end
        end
        if (!rstn) valid = 1;
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic [78:0] act, expv;
        int nn;
        if (valid) begin
            for (int u = 0; u < 2; u++) begin
                nn   = 10 * (((u == 0) ? 1 : 3) + 1);
                act  = {busy_o[u], done_o[u], pass_o[u], err_o[u], fidx_o[u], a_o[u], b_o[u], ctrl_o[u]};
                expv = {(m_run[u] && m_k[u] < nn), (m_run[u] && m_k[u] == nn), m_pass[u],
                        4'(m_err[u]), 4'(m_fidx[u]), m_a[u], m_b[u], m_c[u]};
                n_assert++;
                if (act !== expv) begin
                    n_fail++;
                    $display("FAIL model_cmp unit=%0d cyc=%0d actual=%h expected=%h", u, cyc, act, expv);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_assert++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic pulse_start(int u);
        @(negedge clk);
        st[u] = 1'b1;
        @(negedge clk);
        st[u] = 1'b0;
    endtask

    // Returns cycle of done relative to the current negedge (cycle 0 right after pulse_start).
    task automatic wait_done(int u, output int rel);
        rel = 0;
        while (!done_o[u] && rel < 400) begin
            @(negedge clk);
            rel++;
        end
        if (!done_o[u]) begin
            n_assert++;
            n_fail++;
            $display("FAIL done_timeout unit=%0d actual=none expected=done", u);
        end
    endtask

    initial begin
        int rel, dones, first, c, found;
        int d [2];
        rstn = 1'b0;
        st[0] = 1'b0;
        st[1] = 1'b0;
        mode = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy_o[0]), 32'd0);
        chk("reset_fidx", 32'(fidx_o[0]), 32'hF);
        chk("reset_ctrl", 32'(ctrl_o[1]), 32'd0);
        rstn = 1'b1;

        // Good ALU, single start pulse.
        pulse_start(0);
        chk("busy_cycle0", 32'(busy_o[0]), 32'd1);
        chk("vec0_b", b_o[0], 32'h55555555);
        wait_done(0, rel);
        chk("done_cycle_s1", 32'(rel), 32'd20);
        chk("good_pass", 32'(pass_o[0]), 32'd1);
        chk("good_err", 32'(err_o[0]), 32'd0);
        chk("good_fidx", 32'(fidx_o[0]), 32'hF);
        repeat (3) @(negedge clk);

        // start re-pulsed while busy is ignored.
        pulse_start(0);
        repeat (4) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        c = 5; dones = 0; first = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            c++;
            if (done_o[0]) begin
                dones++;
                first = c;
            end
        end
        chk("busy_restart_dones", 32'(dones), 32'd1);
        chk("busy_restart_cycle", 32'(first), 32'd20);

        // SRA implemented as logical shift.
        mode = 1;
        pulse_start(0);
        wait_done(0, rel);
        chk("sra_pass", 32'(pass_o[0]), 32'd0);
        chk("sra_err", 32'(err_o[0]), 32'd1);
        chk("sra_fidx", 32'(fidx_o[0]), 32'd8);
        repeat (2) @(negedge clk);

        // Zero flag stuck at 0.
        mode = 2;
        pulse_start(0);
        wait_done(0, rel);
        chk("zero_err", 32'(err_o[0]), 32'd2);
        chk("zero_fidx", 32'(fidx_o[0]), 32'd0);
        repeat (2) @(negedge clk);

        // Reset in cycle 7 of a run.
        mode = 0;
        pulse_start(0);
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("midrst_busy", 32'(busy_o[0]), 32'd0);
        chk("midrst_err", 32'(err_o[0]), 32'd0);
        chk("midrst_fidx", 32'(fidx_o[0]), 32'hF);
        chk("midrst_alu_a", a_o[0], 32'd0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_o[0]) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        pulse_start(0);
        wait_done(0, rel);
        chk("post_rst_cycle", 32'(rel), 32'd20);
        chk("post_rst_pass", 32'(pass_o[0]), 32'd1);

        // Settle 3 with start held high: back-to-back runs.
        @(negedge clk);
        st[1] = 1'b1;
        @(negedge clk);
        c = 0; found = 0; d[0] = -1; d[1] = -1;
        while (found < 2 && c < 200) begin
            if (done_o[1]) begin
                d[found] = c;
                found++;
            end
            @(negedge clk);
            c++;
        end
        st[1] = 1'b0;
        chk("held_done_first", 32'(d[0]), 32'd40);
        chk("held_done_second", 32'(d[1]), 32'd81);
        repeat (100) @(negedge clk);

        // Randomized starts, resets and ALU faults, checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            st[0] = ($urandom_range(0, 5) == 0);
            st[1] = ($urandom_range(0, 5) == 0);
            rstn  = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) mode = int'($urandom_range(0, 2));
        end
        @(negedge clk);
        st[0] = 1'b0;
        st[1] = 1'b0;
        rstn  = 1'b1;
        repeat (120) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
